indicator_decoder: RTL

//  Read-back side of the overflow-indicator stage. After a sketch is frozen, it sweeps
//  the 1-bit indicator RAM over all NUM_COUNTER*NUM_SLICE slots and merges each slot's
//  low DIVISOR bits (layer-1 stream) with its upper bits (overflow-layer stream).

---
 rtl/indicator_decoder_pkg.sv | 37 +++
 rtl/indicator_merge.sv | 83 ++++++++
 rtl/indicator_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/indicator_decoder_pkg.sv
// Shared constants, FSM encoding and output payload for the indicator read-back stage.
// DIVISOR must match the indicator writer stage that split the counters.
package indicator_decoder_pkg;

    localparam int unsigned NUM_COUNTER = 10;
    localparam int unsigned NUM_SLICE   = 3;
    localparam int unsigned TOTAL       = NUM_COUNTER * NUM_SLICE;
    localparam int unsigned DIVISOR     = 3;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned UP_W        = CNT_W - DIVISOR;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COLLECT = 3'd3,
        ST_EMIT    = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    // Reconstructed counter as presented downstream.
    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [CNT_W-1:0]  counter;
    } out_word_t;

    // Rebuild a full counter; non-overflowed slots have zero upper bits.
    function automatic logic [CNT_W-1:0] merge_counter(
        input logic               ovf,
        input logic [UP_W-1:0]    up,
        input logic [DIVISOR-1:0] low
    );
        return ovf ? {up, low} : {UP_W'(0), low};
    endfunction

endpackage

// File: rtl/indicator_merge.sv
// One-entry holders for the layer-1 low word and the overflow-layer upper word,
// with registered pop strobes and the counter concatenation.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   arm_i              FSM will be in COLLECT next cycle
//   need_up_d_i/q_i    slot indicator (next / current value)
//   clr_i              drop both held words (slot consumed)
//   low_*_i/o, up_*_i/o  input stream handshakes
//   held_all_c_o       every word required by the slot is held (next-state view)
//   counter_c_o        merged counter built from the next-state holder contents
module indicator_merge
    import indicator_decoder_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               arm_i,
    input  logic               need_up_d_i,
    input  logic               need_up_q_i,
    input  logic               clr_i,
    input  logic               low_valid_i,
    input  logic [DIVISOR-1:0] low_data_i,
    output logic               low_ready_o,
    input  logic               up_valid_i,
    input  logic [UP_W-1:0]    up_data_i,
    output logic               up_ready_o,
    output logic               held_all_c_o,
    output logic [CNT_W-1:0]   counter_c_o
);

    logic               low_vld_q, low_vld_d;
    logic [DIVISOR-1:0] low_q, low_d;
    logic               low_ready_q, low_ready_d;
    logic               up_vld_q, up_vld_d;
    logic [UP_W-1:0]    up_q, up_d;
    logic               up_ready_q, up_ready_d;

    // Capture on handshake; ready drops the cycle after the word is held.
    always_comb begin
        low_vld_d = low_vld_q;
        low_d     = low_q;
        up_vld_d  = up_vld_q;
        up_d      = up_q;
        if (clr_i) begin
            low_vld_d = 1'b0;
            up_vld_d  = 1'b0;
        end else begin
            if (low_valid_i && low_ready_q) begin
                low_vld_d = 1'b1;
                low_d     = low_data_i;
            end
            if (up_valid_i && up_ready_q) begin
                up_vld_d = 1'b1;
                up_d     = up_data_i;
            end
        end
        low_ready_d = arm_i && !low_vld_d;
        up_ready_d  = arm_i && need_up_d_i && !up_vld_d;
    end

    assign held_all_c_o = low_vld_d && (!need_up_q_i || up_vld_d);
    assign counter_c_o  = merge_counter(need_up_q_i, up_d, low_d);
    assign low_ready_o  = low_ready_q;
    assign up_ready_o   = up_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_vld_q   <= 1'b0;
            low_q       <= '0;
            low_ready_q <= 1'b0;
            up_vld_q    <= 1'b0;
            up_q        <= '0;
            up_ready_q  <= 1'b0;
        end else begin
            low_vld_q   <= low_vld_d;
            low_q       <= low_d;
            low_ready_q <= low_ready_d;
            up_vld_q    <= up_vld_d;
            up_q        <= up_d;
            up_ready_q  <= up_ready_d;
        end
    end

endmodule

// File: rtl/indicator_decoder.sv
// Sweeps the indicator RAM over all TOTAL slots after a freeze and emits the
// reconstructed 32-bit counters in index order.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Start / Busy / Done        sweep control and status
//   Ind_Rd_En/Addr/Data        indicator RAM read port (1-cycle latency)
//   Low_Valid/Data/Ready       layer-1 low-bit stream
//   Up_Valid/Data/Ready        overflow-layer upper-bit stream
//   Out_Valid/Index/Counter/Ready  reconstructed counter stream
module indicator_decoder
    import indicator_decoder_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    output logic               Busy,
    output logic               Done,
    output logic               Ind_Rd_En,
    output logic [ADDR_W-1:0]  Ind_Rd_Addr,
    input  logic               Ind_Rd_Data,
    input  logic               Low_Valid,
    input  logic [DIVISOR-1:0] Low_Data,
    output logic               Low_Ready,
    input  logic               Up_Valid,
    input  logic [UP_W-1:0]    Up_Data,
    output logic               Up_Ready,
    output logic               Out_Valid,
    output logic [ADDR_W-1:0]  Out_Index,
    output logic [CNT_W-1:0]   Out_Counter,
    input  logic               Out_Ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ind_q, ind_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              out_valid_q, out_valid_d;
    out_word_t         out_q, out_d;

    logic              clr_c;
    logic              arm_c;
    logic              held_all_c;
    logic [CNT_W-1:0]  counter_c;

    indicator_merge u_merge (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .arm_i        (arm_c),
        .need_up_d_i  (ind_d),
        .need_up_q_i  (ind_q),
        .clr_i        (clr_c),
        .low_valid_i  (Low_Valid),
        .low_data_i   (Low_Data),
        .low_ready_o  (Low_Ready),
        .up_valid_i   (Up_Valid),
        .up_data_i    (Up_Data),
        .up_ready_o   (Up_Ready),
        .held_all_c_o (held_all_c),
        .counter_c_o  (counter_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ind_d   = ind_q;
        out_d   = out_q;
        clr_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                ind_d   = Ind_Rd_Data;
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (held_all_c) begin
                    out_d.index   = idx_q;
                    out_d.counter = counter_c;
                    state_d       = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_valid_q && Out_Ready) begin
                    clr_c = 1'b1;
                    if (idx_q == ADDR_W'(TOTAL - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        arm_c       = (state_d == ST_COLLECT);
        busy_d      = (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                      (state_d == ST_COLLECT) || (state_d == ST_EMIT);
        done_d      = (state_d == ST_FIN);
        rd_en_d     = (state_d == ST_FETCH);
        rd_addr_d   = (state_d == ST_FETCH) ? idx_d : rd_addr_q;
        out_valid_d = (state_d == ST_EMIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ind_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ind_q       <= ind_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Ind_Rd_En   = rd_en_q;
    assign Ind_Rd_Addr = rd_addr_q;
    assign Out_Valid   = out_valid_q;
    assign Out_Index   = out_q.index;
    assign Out_Counter = out_q.counter;

endmodule
